// File: rtl/shift_reg_cnt_pkg.sv
// Shared mode encoding for the shift register with shift counter.
package shift_reg_pkg;

   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_LOAD = 2'b01,
      MODE_SHL  = 2'b10,
      MODE_SHR  = 2'b11
   } mode_t;

   function automatic logic is_shift(input mode_t m);
      return (m == MODE_SHL) || (m == MODE_SHR);
   endfunction

endpackage

// File: rtl/shift_reg_cnt_if.sv
// Control/data bundle between a driver (master) and shift_reg_cnt (slave).
interface shift_reg_cnt_if
   import shift_reg_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int MAX_SHIFTS = WIDTH
);
   localparam int CNT_W = $clog2(MAX_SHIFTS + 1);

   logic             clear;
   mode_t            mode;
   logic [WIDTH-1:0] data_in;
   logic             serial_in;
   logic [WIDTH-1:0] data_out;
   logic             serial_out;
   logic [CNT_W-1:0] shift_cnt;
   logic             done;

   modport master (
      output clear, mode, data_in, serial_in,
      input  data_out, serial_out, shift_cnt, done
   );

   modport slave (
      input  clear, mode, data_in, serial_in,
      output data_out, serial_out, shift_cnt, done
   );
endinterface

// File: rtl/shift_reg_cnt_sat_counter.sv
// Up-counter that saturates at MAX; reset has priority over clr, clr over inc.
module sat_counter #(
   parameter int MAX = 8,
   parameter int W   = $clog2(MAX + 1)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);
   localparam logic [W-1:0] MAX_C = W'(MAX);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         cnt <= '0;
      end else if (inc && (cnt != MAX_C)) begin
         cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/shift_reg_cnt.sv
// Loadable bidirectional shift register with saturating shift counter.
// Counter and done exist only when SHIFT_REG_CNT_EN is defined; otherwise they read 0.
module shift_reg_cnt
   import shift_reg_pkg::*;
#(
   parameter int               WIDTH      = 8,
   parameter logic [WIDTH-1:0] RST_VAL    = '0,
   parameter int               MAX_SHIFTS = WIDTH
) (
   input logic            clk,
   input logic            reset,
   shift_reg_cnt_if.slave bus
);
   localparam int CNT_W = $clog2(MAX_SHIFTS + 1);

   logic [WIDTH-1:0] data_q;

   always_ff @(posedge clk) begin
      if (reset || bus.clear) begin
         data_q <= RST_VAL;
      end else begin
         case (bus.mode)
            MODE_LOAD: data_q <= bus.data_in;
            MODE_SHL:  data_q <= {data_q[WIDTH-2:0], bus.serial_in};
            MODE_SHR:  data_q <= {bus.serial_in, data_q[WIDTH-1:1]};
            default:   data_q <= data_q;
         endcase
      end
   end

   assign bus.data_out   = data_q;
   // The bit that would leave on a left shift is the MSB; every other mode exposes the LSB.
   assign bus.serial_out = (bus.mode == MODE_SHL) ? data_q[WIDTH-1] : data_q[0];

`ifdef SHIFT_REG_CNT_EN
   logic [CNT_W-1:0] cnt;

   // A load restarts the count just like clear does.
   sat_counter #(
      .MAX (MAX_SHIFTS),
      .W   (CNT_W)
   ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (bus.clear || (bus.mode == MODE_LOAD)),
      .inc   (is_shift(bus.mode)),
      .cnt   (cnt)
   );

   assign bus.shift_cnt = cnt;
   assign bus.done      = (cnt == CNT_W'(MAX_SHIFTS));
`else
   assign bus.shift_cnt = '0;
   assign bus.done      = 1'b0;
`endif

endmodule
